// File: rtl/uart_tx_feeder_if.sv
// Purpose : bundles the byte-write side, the UART transmitter handshake and
//           the status flags of uart_tx_feeder into one connection.
// Ports   : master = producer/transmitter side (drives wr_*, clr_ovf,
//           tx_busy, tx_done); slave = the feeder (drives tx_*, flags, count).
// Latency : n/a (wiring only). Backpressure: n/a (wiring only).
interface uart_tx_feeder_if;
   // producer side
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_ovf;
   // downstream transmitter status
   logic       tx_busy;
   logic       tx_done;
   // launch towards the transmitter
   logic       tx_en;
   logic [7:0] tx_data;
   // status
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       active;

   modport master (
      output wr_en, wr_data, clr_ovf, tx_busy, tx_done,
      input  tx_en, tx_data, full, empty, count, overflow, active
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf, tx_busy, tx_done,
      output tx_en, tx_data, full, empty, count, overflow, active
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Purpose : 16x8 byte FIFO that feeds a UART transmitter one frame at a time
//           (IDLE -> LAUNCH -> WAIT_DONE), with a sticky overflow flag.
// Latency : write at edge N into an empty idle FIFO -> tx_en high in the cycle
//           after edge N+1; next launch no sooner than 2 cycles after tx_done.
// Backpressure: writes while full are dropped and set overflow; launches wait
//           for tx_busy=0 and for tx_done of the previous frame.
// Ports   : clk, rst (sync, active-high); bus (slave modport) carrying
//           wr_en/wr_data/clr_ovf in, tx_busy/tx_done in, tx_en/tx_data out,
//           full/empty/count/overflow/active out.
module uart_tx_feeder (
   input  logic             clk,
   input  logic             rst,
   uart_tx_feeder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   localparam logic [4:0] DEPTH = 5'd16;

   state_t     state_q, state_d;
   logic [7:0] mem_q [16];
   logic [3:0] wr_ptr_q, wr_ptr_d;
   logic [3:0] rd_ptr_q, rd_ptr_d;
   logic [4:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic [7:0] tx_data_q, tx_data_d;

   logic       full;
   logic       empty;
   logic       push;
   logic       drop;
   logic       pop;

   // Flags come from the registered count only, so wr_en never reaches them
   // combinationally.
   assign full  = (count_q == DEPTH);
   assign empty = (count_q == 5'd0);

   // full is the pre-edge value: a write that finds the FIFO full is lost
   // even if the FSM frees a slot on the same edge.
   assign push  = bus.wr_en & ~full;
   assign drop  = bus.wr_en &  full;

   // ------------------------------------------------------------------
   // FSM: next state, pop request and launch byte
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      tx_data_d = tx_data_q;
      case (state_q)
         S_IDLE: begin
            // The head byte is captured and popped on the same edge that
            // enters LAUNCH, so tx_data is already valid while tx_en is high.
            if (!empty && !bus.tx_busy) begin
               state_d   = S_LAUNCH;
               pop       = 1'b1;
               tx_data_d = mem_q[rd_ptr_q];
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // tx_done is only looked at here; pulses in other states are lost.
            if (bus.tx_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      // 4-bit pointers wrap 15 -> 0 naturally.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 4'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 4'd1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase

      // A drop wins over a clear in the same cycle so the loss is not hidden.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= 4'd0;
         rd_ptr_q  <= 4'd0;
         count_q   <= 5'd0;
         ovf_q     <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Storage is not cleared; resetting the pointers/count discards contents.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.tx_en    = (state_q == S_LAUNCH);
   assign bus.tx_data  = tx_data_q;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
   assign bus.active   = (state_q != S_IDLE);

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count_q <= DEPTH);

   a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
      pop |-> !empty);

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   uart_tx_feeder_if bus ();

   uart_tx_feeder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are read on the falling edge
   // and reflect the state after the preceding rising edge.

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_en = 1'b1;      // must be ignored while in reset
      bus.wr_data = 8'hFF;
      bus.clr_ovf = 1'b0;
      bus.tx_busy = 1'b0;
      bus.tx_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b exp 0", bus.tx_en); end
      checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", bus.active); end
      rst = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic test_single();
      bus.tx_busy = 1'b0;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hA5;
      @(negedge clk);                    // write edge N has passed
      bus.wr_en = 1'b0;
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count_after_write got %0d exp 1", bus.count); end
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL single_tx_en_early got %b exp 0", bus.tx_en); end
      @(negedge clk);                    // edge N+1: pop, enter LAUNCH
      checks++; if (bus.tx_en !== 1'b1) begin errors++; $display("FAIL single_tx_en got %b exp 1", bus.tx_en); end
      checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %h exp a5", bus.tx_data); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop got %0d exp 0", bus.count); end
      checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL single_active_launch got %b exp 1", bus.active); end
      @(negedge clk);                    // WAIT_DONE
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL single_tx_en_one_cycle got %b exp 0", bus.tx_en); end
      @(negedge clk);
      checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL single_active_wait got %b exp 1", bus.active); end
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL single_active_after_done got %b exp 0", bus.active); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", bus.empty); end
   endtask

   task automatic test_fill_overflow();
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = 8'(i);
         @(negedge clk);
      end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", bus.count); end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", bus.full); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got %b exp 0", bus.overflow); end
      bus.wr_data = 8'h10;               // 17th byte, must be dropped
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", bus.overflow); end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count_after_drop got %0d exp 16", bus.count); end
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_clr_ovf got %b exp 0", bus.overflow); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL fill_busy_holds_idle got %b exp 0", bus.active); end
   endtask

   task automatic test_full_pop_drop();
      // count=16: release tx_busy and write on the same edge the FSM pops.
      bus.tx_busy = 1'b0;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hEE;
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fullpop_count got %0d exp 15", bus.count); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow got %b exp 1", bus.overflow); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fullpop_full got %b exp 0", bus.full); end
   endtask

   task automatic test_drain_wrap();
      // Entry: FSM is in LAUNCH for the first byte.
      for (int k = 0; k < 16; k++) begin
         checks++; if (bus.tx_en !== 1'b1) begin errors++; $display("FAIL drain_tx_en[%0d] got %b exp 1", k, bus.tx_en); end
         checks++; if (bus.tx_data !== 8'(k)) begin errors++; $display("FAIL drain_tx_data[%0d] got %h exp %h", k, bus.tx_data, 8'(k)); end
         checks++; if (bus.count !== 5'(15 - k)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, bus.count, 15 - k); end
         @(negedge clk);                 // WAIT_DONE
         checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL drain_wait_tx_en[%0d] got %b exp 0", k, bus.tx_en); end
         bus.tx_done = 1'b1;
         @(negedge clk);                 // back in IDLE
         bus.tx_done = 1'b0;
         checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL drain_idle_tx_en[%0d] got %b exp 0", k, bus.tx_en); end
         @(negedge clk);                 // next LAUNCH, if any byte remains
      end
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL drain_end_tx_en got %b exp 0", bus.tx_en); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_end_empty got %b exp 1", bus.empty); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL drain_end_active got %b exp 0", bus.active); end
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
   endtask

   task automatic test_push_pop();
      bus.tx_busy = 1'b1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h51;
      @(negedge clk);
      bus.wr_data = 8'h52;
      @(negedge clk);
      bus.wr_data = 8'h53;               // push and pop on the same edge
      bus.tx_busy = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.tx_busy = 1'b1;
      checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL pushpop_count got %0d exp 2", bus.count); end
      checks++; if (bus.tx_data !== 8'h51) begin errors++; $display("FAIL pushpop_tx_data got %h exp 51", bus.tx_data); end
   endtask

   task automatic test_reset_wait();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = 8'(48 + i);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      bus.tx_busy = 1'b0;
      @(negedge clk);                    // LAUNCH with 0x30
      checks++; if (bus.tx_data !== 8'h30) begin errors++; $display("FAIL rstwait_tx_data got %h exp 30", bus.tx_data); end
      @(negedge clk);                    // WAIT_DONE
      checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL rstwait_count_pre got %0d exp 5", bus.count); end
      checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL rstwait_active_pre got %b exp 1", bus.active); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rstwait_count got %0d exp 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstwait_empty got %b exp 1", bus.empty); end
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL rstwait_tx_en got %b exp 0", bus.tx_en); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rstwait_active got %b exp 0", bus.active); end
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      @(negedge clk);
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL rstwait_late_done_tx_en got %b exp 0", bus.tx_en); end
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rstwait_late_done_active got %b exp 0", bus.active); end
   endtask

   task automatic test_done_idle();
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL doneidle_active got %b exp 0", bus.active); end
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL doneidle_tx_en got %b exp 0", bus.tx_en); end
      @(negedge clk);
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL doneidle_tx_en_next got %b exp 0", bus.tx_en); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL doneidle_count got %0d exp 0", bus.count); end
   endtask

   task automatic test_ovf_priority();
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = 8'(128 + i);
         @(negedge clk);
      end
      bus.clr_ovf = 1'b1;                // dropped write and clear together
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovfprio_overflow got %b exp 1", bus.overflow); end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovfprio_count got %0d exp 16", bus.count); end
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovfprio_clear got %b exp 0", bus.overflow); end
      rst = 1'b1;
      bus.wr_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.wr_en = 1'b0;
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL ovfprio_reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL ovfprio_reset_full got %b exp 0", bus.full); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_pop_drop();
      test_drain_wrap();
      test_push_pop();
      test_reset_wait();
      test_done_idle();
      test_ovf_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
